// File: rtl/bht_predictor.sv
// Branch history table with one-cycle lookup latency.
// Each direct-mapped entry holds a valid bit, a tag, a target and a saturating counter.
// The misprediction event counter saturates at 16'hFFFF.
module bht_predictor #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 64,
    parameter int CTR_W = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_mispred,
    input  logic            flush,
    output logic [15:0]     mispred_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [PC_W-1:0]  tgt_q [DEPTH];
    logic [CTR_W-1:0] ctr_q [DEPTH];

    logic            pred_valid_q, pred_hit_q, pred_taken_q;
    logic [PC_W-1:0] pred_target_q;
    logic [15:0]     mispred_q;

    // Lookup path reads the array as it stands before this edge's update lands,
    // which gives same-cycle lookup/update collisions the pre-update contents.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit, lk_taken;
    logic [PC_W-1:0]  lk_tgt;

    assign lk_idx   = lk_pc[IDX_W+1:2];
    assign lk_tag   = lk_pc[PC_W-1:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign lk_tgt   = lk_taken ? tgt_q[lk_idx] : lk_pc + PC_W'(4);

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_d;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Next counter value: saturating train on a hit, weak-state seed on allocation
    always_comb begin
        ctr_d = ctr_q[upd_idx];
        if (upd_hit) begin
            if (upd_taken && ctr_q[upd_idx] != CTR_MAX)
                ctr_d = ctr_q[upd_idx] + CTR_W'(1);
            else if (!upd_taken && ctr_q[upd_idx] != '0)
                ctr_d = ctr_q[upd_idx] - CTR_W'(1);
        end else begin
            ctr_d = upd_taken ? CTR_WT : CTR_WNT;
        end
    end

    // Valid bits: flush dominates any same-cycle allocation
    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = '0;
        else if (upd_valid)
            valid_d[upd_idx] = 1'b1;
    end

    // Valid-bit state, the only table state that needs a reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    // Tag/target/counter storage; a flushed update is dropped entirely
    always_ff @(posedge clock) begin
        if (upd_valid && !flush) begin
            tag_q[upd_idx] <= upd_tag;
            ctr_q[upd_idx] <= ctr_d;
            if (!upd_hit || upd_taken)
                tgt_q[upd_idx] <= upd_target;
        end
    end

    // Prediction register: outputs hold when no lookup is issued
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q <= lk_valid;
            if (lk_valid) begin
                pred_hit_q    <= lk_hit;
                pred_taken_q  <= lk_taken;
                pred_target_q <= lk_tgt;
            end
        end
    end

    // Saturating misprediction event counter, untouched by flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            mispred_q <= '0;
        else if (upd_mispred && mispred_q != 16'hFFFF)
            mispred_q <= mispred_q + 16'd1;
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign mispred_cnt = mispred_q;
endmodule
